// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and per-opcode latency helpers for the ALU arbiter.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_DIV = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_MUL = 4'b0111;
  localparam logic [3:0] ALU_NOP = 4'b1111;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

  function automatic logic is_legal(input logic [3:0] ctrl);
    return ctrl inside {ALU_AND, ALU_OR, ALU_ADD, ALU_DIV, ALU_SUB, ALU_MUL};
  endfunction

  function automatic int unsigned lat_of(input logic [3:0] ctrl, input int unsigned lat_alu,
                                         input int unsigned lat_mul, input int unsigned lat_div);
    case (ctrl)
      ALU_MUL: return lat_mul;
      ALU_DIV: return lat_div;
      default: return lat_alu;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer flips to the other requester on every accept.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic [1:0] valid_i,
  output logic [1:0] gnt_o
);

  logic ptr_q, ptr_d;
  logic gnt_id;

  // Every granted request is accepted the same cycle, so grant doubles as accept.
  always_comb begin
    gnt_id = (valid_i == 2'b11) ? ptr_q : valid_i[1];
    gnt_o  = 2'b00;
    ptr_d  = ptr_q;
    if (en_i && (|valid_i)) begin
      gnt_o[gnt_id] = 1'b1;
      ptr_d         = ~gnt_id;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters: round-robin grant, one op in flight, operands held
// for a per-opcode latency, result registered into a tagged response with backpressure.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned LAT_ALU = 1,
  parameter int unsigned LAT_MUL = 4,
  parameter int unsigned LAT_DIV = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_ctrl,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_ctrl,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_ovf,
  input  logic [WIDTH-1:0] alu_rem,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_ovf,
  output logic [WIDTH-1:0] rsp_rem,
  output logic             rsp_err
);

  localparam int unsigned MaxAM  = (LAT_ALU > LAT_MUL) ? LAT_ALU : LAT_MUL;
  localparam int unsigned MaxLat = (MaxAM > LAT_DIV) ? MaxAM : LAT_DIV;
  localparam int unsigned CntW   = $clog2(MaxLat) + 1;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] in1_q, in1_d, in2_q, in2_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic             rsp_id_q, rsp_id_d, rsp_zero_q, rsp_zero_d;
  logic             rsp_ovf_q, rsp_ovf_d, rsp_err_q, rsp_err_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d, rsp_rem_q, rsp_rem_d;

  logic [1:0]       gnt;
  logic             accept, sel_id;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [3:0]       sel_ctrl;

  // Gating with rst_n keeps ready low while reset is held.
  rr_arbiter2 u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   ((state_q == StIdle) && rst_n),
    .valid_i({req1_valid, req0_valid}),
    .gnt_o  (gnt)
  );

  assign accept   = |gnt;
  assign sel_id   = gnt[1];
  assign sel_a    = sel_id ? req1_a : req0_a;
  assign sel_b    = sel_id ? req1_b : req0_b;
  assign sel_ctrl = sel_id ? req1_ctrl : req0_ctrl;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    id_d         = id_q;
    in1_d        = in1_q;
    in2_d        = in2_q;
    ctrl_d       = ctrl_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_rem_d    = rsp_rem_q;
    rsp_err_d    = rsp_err_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          id_d     = sel_id;
          rsp_id_d = sel_id;
          if (!is_legal(sel_ctrl)) begin
            rsp_result_d = '0;
            rsp_zero_d   = 1'b1;
            rsp_ovf_d    = 1'b0;
            rsp_rem_d    = '0;
            rsp_err_d    = 1'b1;
            state_d      = StResp;
          end else if ((sel_ctrl == ALU_DIV) && (sel_b == '0)) begin
            // Divide by zero never reaches the ALU.
            rsp_result_d = '1;
            rsp_zero_d   = 1'b0;
            rsp_ovf_d    = 1'b0;
            rsp_rem_d    = sel_a;
            rsp_err_d    = 1'b1;
            state_d      = StResp;
          end else begin
            in1_d   = sel_a;
            in2_d   = sel_b;
            ctrl_d  = sel_ctrl;
            cnt_d   = CntW'(lat_of(sel_ctrl, LAT_ALU, LAT_MUL, LAT_DIV) - 32'd1);
            state_d = StExec;
          end
        end
      end
      StExec: begin
        if (cnt_q == '0) begin
          rsp_result_d = alu_result;
          rsp_zero_d   = alu_zero;
          rsp_ovf_d    = alu_ovf;
          rsp_rem_d    = (ctrl_q == ALU_DIV) ? alu_rem : '0;
          rsp_err_d    = 1'b0;
          ctrl_d       = ALU_NOP;
          state_d      = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      id_q         <= 1'b0;
      in1_q        <= '0;
      in2_q        <= '0;
      ctrl_q       <= ALU_NOP;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_ovf_q    <= 1'b0;
      rsp_rem_q    <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      id_q         <= id_d;
      in1_q        <= in1_d;
      in2_q        <= in2_d;
      ctrl_q       <= ctrl_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_rem_q    <= rsp_rem_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign alu_in1    = in1_q;
  assign alu_in2    = in2_q;
  assign alu_ctrl   = ctrl_q;
  assign rsp_valid  = (state_q == StResp);
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_ovf    = rsp_ovf_q;
  assign rsp_rem    = rsp_rem_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a latency-aware ALU model, per-requester expected queues
// and a response monitor that pops and compares on every rsp handshake.
module tb_alu_arbiter;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_MUL = 4'b0111;
  localparam logic [3:0] OP_NOP = 4'b1111;
  localparam logic [3:0] OP_BAD = 4'b0101;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0, req0_ready, req1_ready;
  logic [63:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0]  req0_ctrl = '0, req1_ctrl = '0;
  logic [63:0] alu_in1, alu_in2, alu_result, alu_rem;
  logic [3:0]  alu_ctrl;
  logic        alu_zero, alu_ovf;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_zero, rsp_ovf, rsp_err;
  logic [63:0] rsp_result, rsp_rem;

  alu_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req0_ctrl (req0_ctrl),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .req1_ctrl (req1_ctrl),
    .alu_in1   (alu_in1),
    .alu_in2   (alu_in2),
    .alu_ctrl  (alu_ctrl),
    .alu_result(alu_result),
    .alu_zero  (alu_zero),
    .alu_ovf   (alu_ovf),
    .alu_rem   (alu_rem),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_result(rsp_result),
    .rsp_zero  (rsp_zero),
    .rsp_ovf   (rsp_ovf),
    .rsp_rem   (rsp_rem),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ALU model: result is garbage until inputs have been stable for the opcode's latency.
  function automatic int unsigned lat(input logic [3:0] c);
    if (c == OP_MUL) return 4;
    if (c == OP_DIV) return 8;
    return 1;
  endfunction

  logic [131:0] alu_key, prev_key = '0;
  int unsigned  hold = 0, age;
  logic [63:0]  m_res;
  assign alu_key = {alu_in1, alu_in2, alu_ctrl};
  assign age     = (alu_key == prev_key) ? hold + 1 : 1;
  always @(posedge clk) begin
    prev_key <= alu_key;
    hold     <= age;
  end

  always_comb begin
    m_res   = '0;
    alu_rem = alu_in1 ^ alu_in2;
    alu_ovf = 1'b0;
    case (alu_ctrl)
      OP_AND: m_res = alu_in1 & alu_in2;
      OP_OR:  m_res = alu_in1 | alu_in2;
      OP_ADD: begin
        m_res   = alu_in1 + alu_in2;
        alu_ovf = (alu_in1[63] == alu_in2[63]) && (m_res[63] != alu_in1[63]);
      end
      OP_SUB: begin
        m_res   = alu_in1 - alu_in2;
        alu_ovf = (alu_in1[63] != alu_in2[63]) && (m_res[63] != alu_in1[63]);
      end
      OP_MUL: m_res = alu_in1 * alu_in2;
      OP_DIV: begin
        if (alu_in2 != '0) begin
          m_res   = alu_in1 / alu_in2;
          alu_rem = alu_in1 % alu_in2;
        end else begin
          m_res   = '1;
          alu_rem = alu_in1;
        end
      end
      default: m_res = '0;
    endcase
    if (age < lat(alu_ctrl)) begin
      m_res   = 64'hBAD0_BAD0_BAD0_BAD0;
      alu_ovf = 1'b1;
    end
    alu_result = m_res;
    alu_zero   = (m_res == '0);
  end

  logic div_seen = 1'b0;
  always @(negedge clk) if (alu_ctrl == OP_DIV) div_seen = 1'b1;

  typedef struct packed {
    logic        id;
    logic [63:0] res;
    logic        zero;
    logic        ovf;
    logic [63:0] rem;
    logic        err;
  } rsp_t;

  rsp_t q0[$];
  rsp_t q1[$];

  task automatic push(input logic id, input logic [63:0] res, input logic z, input logic o,
                      input logic [63:0] rem, input logic e);
    rsp_t r;
    r = {id, res, z, o, rem, e};
    if (id) q1.push_back(r);
    else q0.push_back(r);
  endtask

  always @(negedge clk) begin
    rsp_t act, exp_r;
    #3;
    if (rst_n && rsp_valid && rsp_ready) begin
      act = {rsp_id, rsp_result, rsp_zero, rsp_ovf, rsp_rem, rsp_err};
      if ((rsp_id && q1.size() == 0) || (!rsp_id && q0.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got %0h expected none", act);
      end else begin
        exp_r = rsp_id ? q1.pop_front() : q0.pop_front();
        check("rsp", act, exp_r);
      end
    end
  end

  // Called near a negedge; returns just after the accepting posedge with valid dropped.
  task automatic issue(input int n, input logic [63:0] a, input logic [63:0] b,
                       input logic [3:0] c, output int acc);
    bit got = 1'b0;
    acc = 0;
    if (n == 0) begin
      req0_a = a; req0_b = b; req0_ctrl = c; req0_valid = 1'b1;
    end else begin
      req1_a = a; req1_b = b; req1_ctrl = c; req1_valid = 1'b1;
    end
    for (int i = 0; i < 64 && !got; i++) begin
      #1;
      if ((n == 0) ? req0_ready : req1_ready) begin
        @(posedge clk);
        #1;
        acc = cyc;
        got = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (n == 0) req0_valid = 1'b0;
    else req1_valid = 1'b0;
    check("accept", got, 1'b1);
  endtask

  task automatic wait_valid(output int edges, output int ndiv);
    edges = 0;
    ndiv  = 0;
    @(negedge clk);
    while (!rsp_valid && edges < 40) begin
      if (alu_ctrl == OP_DIV) ndiv++;
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc_a1, acc_a2, acc_b, edges, ndiv, good, h, nv;

    // Reset with a pending request.
    req0_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("reset", {req0_ready, rsp_valid, alu_ctrl, alu_in1, alu_in2, rsp_result, rsp_err},
          {1'b0, 1'b0, OP_NOP, 64'd0, 64'd0, 64'd0, 1'b0});
    req0_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    push(1'b0, 64'd12, 1'b0, 1'b0, 64'd0, 1'b0);
    issue(0, 64'd5, 64'd7, OP_ADD, acc);
    wait_valid(edges, ndiv);
    check("add_latency", edges, 1);

    push(1'b0, 64'hF, 1'b0, 1'b0, 64'd0, 1'b0);
    issue(0, 64'hA, 64'h5, OP_OR, acc);
    wait_valid(edges, ndiv);

    push(1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 64'd0, 1'b0);
    issue(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, OP_ADD, acc);
    wait_valid(edges, ndiv);

    // Contention from a fresh pointer; req0 re-requests and must wait behind req1.
    do_reset();
    fork
      begin
        push(1'b0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b0);
        issue(0, 64'd9, 64'd9, OP_SUB, acc_a1);
        push(1'b0, 64'd2, 1'b0, 1'b0, 64'd0, 1'b0);
        issue(0, 64'd1, 64'd1, OP_ADD, acc_a2);
      end
      begin
        push(1'b1, 64'd12, 1'b0, 1'b0, 64'd0, 1'b0);
        issue(1, 64'd3, 64'd4, OP_MUL, acc_b);
      end
      begin
        #2;
        check("grant_both", {req0_ready, req1_ready}, 2'b10);
      end
    join
    check("rr_order", {acc_a1 < acc_b, acc_b < acc_a2}, 2'b11);
    repeat (20) @(negedge clk);

    push(1'b0, 64'd3, 1'b0, 1'b0, 64'd2, 1'b0);
    issue(0, 64'd17, 64'd5, OP_DIV, acc);
    wait_valid(edges, ndiv);
    check("div_latency", edges, 8);
    check("div_ctrl_held", ndiv, 8);
    check("ctrl_nop_after", alu_ctrl, OP_NOP);

    push(1'b0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1);
    issue(0, 64'd3, 64'd4, OP_BAD, acc);
    wait_valid(edges, ndiv);
    check("illegal_latency", edges, 0);

    @(negedge clk);
    div_seen = 1'b0;
    push(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 64'd9, 1'b1);
    issue(0, 64'd9, 64'd0, OP_DIV, acc);
    wait_valid(edges, ndiv);
    check("div0_latency", edges, 0);
    repeat (2) @(negedge clk);
    check("div0_no_alu", div_seen, 1'b0);

    // Backpressure: response held, second requester blocked.
    rsp_ready = 1'b0;
    push(1'b0, 64'h30, 1'b0, 1'b0, 64'd0, 1'b0);
    issue(0, 64'hF0, 64'h3C, OP_AND, acc);
    wait_valid(edges, ndiv);
    check("and_latency", edges, 1);
    req1_a = 64'hA; req1_b = 64'h5; req1_ctrl = OP_OR; req1_valid = 1'b1;
    good = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (rsp_valid && rsp_result == 64'h30 && !rsp_id && !rsp_err && !req1_ready) good++;
      @(negedge clk);
    end
    check("bp_hold", good, 5);
    h = cyc;
    rsp_ready = 1'b1;
    #1;
    check("hs_no_accept", req1_ready, 1'b0);
    push(1'b1, 64'hF, 1'b0, 1'b0, 64'd0, 1'b0);
    issue(1, 64'hA, 64'h5, OP_OR, acc);
    check("accept_after_hs", acc - h, 2);
    wait_valid(edges, ndiv);

    // Abort mid-EXEC.
    @(negedge clk);
    issue(0, 64'd100, 64'd7, OP_DIV, acc);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_ctrl", alu_ctrl, OP_NOP);
    nv = 0;
    for (int i = 0; i < 15; i++) begin
      if (rsp_valid) nv++;
      @(negedge clk);
    end
    check("abort_no_rsp", nv, 0);

    push(1'b0, 64'd8, 1'b0, 1'b0, 64'd0, 1'b0);
    issue(0, 64'd3, 64'd5, OP_ADD, acc);
    wait_valid(edges, ndiv);
    check("recover_latency", edges, 1);

    repeat (5) @(negedge clk);
    check("queues_empty", q0.size() + q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
